pwm_capture: RTL and testbench

Receive-side counterpart of the dead-time PWM stage: samples a complementary gate pair (`s`, `nots`) and measures, once per PWM period, high time, period, and both dead-time gaps. It flags shoot-through (both legs high) and publishes one result set per period with a single-cycle `valid` strobe. It sits on the monitoring/feedback path of the converter controller, clocked from the 100 MHz system clock.

---
 rtl/pwm_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures a complementary gate pair (s, nots) once per PWM
// period and reports high time, period, both dead-time gaps, a saturation
// flag and a shoot-through fault.
// Optional build macro: PWM_CAPTURE_FAULT_LATCH_EN makes fault sticky until
// fault_clr is asserted while no overlap is present.
module pwm_capture #(
    parameter int DIV  = 100,
    parameter int W    = 11,
    parameter int DT_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s,
    input  logic            nots,
    input  logic            fault_clr,
    output logic [W-1:0]    duty,
    output logic [W-1:0]    period,
    output logic [DT_W-1:0] dt_fall,
    output logic [DT_W-1:0] dt_rise,
    output logic            valid,
    output logic            stuck,
    output logic            fault
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]    CNT_MAX  = '1;
    localparam logic [DT_W-1:0] DT_MAX   = '1;

    typedef enum logic [2:0] {SYNC, HIGH, DT_FALL, LOW, DT_RISE} state_t;

    state_t state, state_next;

    logic            s_m, s_q, s_p;
    logic            n_m, n_q, n_p;
    logic [2:0]      fill;
    logic            s_rise, s_fall, n_rise, n_fall;
    logic            overlap;
    logic [PW-1:0]   pre_cnt;
    logic            tick;
    logic [W-1:0]    duty_cnt, per_cnt;
    logic [W-1:0]    duty_inc, per_inc, per_next;
    logic [DT_W-1:0] dtf_cnt, dtr_cnt;
    logic [DT_W-1:0] dtf_inc, dtr_inc;
    logic            pub, pub_dtf, pub_dtr, sat_pub, clr;

    // Two-flop synchronizers plus one history flop per leg for edge detection;
    // fill marks when the history flop holds a real pin sample after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_m  <= 1'b0;
            s_q  <= 1'b0;
            s_p  <= 1'b0;
            n_m  <= 1'b0;
            n_q  <= 1'b0;
            n_p  <= 1'b0;
            fill <= 3'b000;
        end else begin
            s_m  <= s;
            s_q  <= s_m;
            s_p  <= s_q;
            n_m  <= nots;
            n_q  <= n_m;
            n_p  <= n_q;
            fill <= {fill[1:0], 1'b1};
        end
    end

    assign s_rise  = s_q & ~s_p;
    assign s_fall  = ~s_q & s_p;
    assign n_rise  = n_q & ~n_p;
    assign n_fall  = ~n_q & n_p;
    assign overlap = s_q & n_q;

    // Free-running prescaler producing one tick every DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    assign duty_inc = (duty_cnt == CNT_MAX) ? duty_cnt : duty_cnt + W'(1);
    assign per_inc  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + W'(1);
    assign per_next = tick ? per_inc : per_cnt;
    assign dtf_inc  = (dtf_cnt == DT_MAX) ? dtf_cnt : dtf_cnt + DT_W'(1);
    assign dtr_inc  = (dtr_cnt == DT_MAX) ? dtr_cnt : dtr_cnt + DT_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and publish decisions; an early s rise closes the
    // period and any gap that never completed is reported as zero.
    always_comb begin
        state_next = state;
        pub        = 1'b0;
        pub_dtf    = 1'b0;
        pub_dtr    = 1'b0;
        sat_pub    = 1'b0;
        clr        = 1'b0;
        case (state)
            SYNC: begin
                if (s_rise && fill[2]) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (s_fall) begin
                    state_next = DT_FALL;
                end
            end
            DT_FALL: begin
                if (s_rise) begin
                    pub        = 1'b1;
                    state_next = HIGH;
                end else if (n_rise) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (s_rise) begin
                    pub        = 1'b1;
                    pub_dtf    = 1'b1;
                    state_next = HIGH;
                end else if (n_fall) begin
                    state_next = DT_RISE;
                end
            end
            DT_RISE: begin
                if (s_rise) begin
                    pub        = 1'b1;
                    pub_dtf    = 1'b1;
                    pub_dtr    = 1'b1;
                    state_next = HIGH;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
        if ((state != SYNC) && !pub && (per_cnt == CNT_MAX)) begin
            sat_pub = 1'b1;
        end
        clr = pub | sat_pub | (state == SYNC);
    end

    // Measurement counters: duty and period in ticks, dead times in clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cnt <= '0;
            per_cnt  <= '0;
            dtf_cnt  <= '0;
            dtr_cnt  <= '0;
        end else if (clr) begin
            duty_cnt <= '0;
            per_cnt  <= '0;
            dtf_cnt  <= '0;
            dtr_cnt  <= '0;
        end else begin
            if (tick && (state == HIGH)) begin
                duty_cnt <= duty_inc;
            end
            per_cnt <= per_next;
            if (state == DT_FALL) begin
                dtf_cnt <= dtf_inc;
            end
            if (state == DT_RISE) begin
                dtr_cnt <= dtr_inc;
            end
        end
    end

    // Result registers, updated only together with the valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty    <= '0;
            period  <= '0;
            dt_fall <= '0;
            dt_rise <= '0;
            valid   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            valid <= pub | sat_pub;
            if (pub) begin
                duty    <= duty_cnt;
                period  <= per_next;
                dt_fall <= pub_dtf ? dtf_cnt : '0;
                dt_rise <= pub_dtr ? dtr_inc : '0;
                stuck   <= 1'b0;
            end else if (sat_pub) begin
                duty    <= s_q ? CNT_MAX : '0;
                period  <= CNT_MAX;
                dt_fall <= '0;
                dt_rise <= '0;
                stuck   <= 1'b1;
            end
        end
    end

`ifdef PWM_CAPTURE_FAULT_LATCH_EN
    // Sticky shoot-through flag; a live overlap beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (overlap) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;

    // Shoot-through flag follows the synchronized overlap one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= overlap;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized directed bench for pwm_capture, run with a
// short prescaler and narrow counters so every boundary is reachable quickly.
module tb_pwm_capture;

    localparam int DIV  = 5;
    localparam int W    = 7;
    localparam int DT_W = 6;
    localparam int MAXP = (1 << W) - 1;
    localparam int MAXD = (1 << DT_W) - 1;
`ifdef PWM_CAPTURE_FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            s;
    logic            nots;
    logic            fault_clr;
    logic [W-1:0]    duty;
    logic [W-1:0]    period;
    logic [DT_W-1:0] dt_fall;
    logic [DT_W-1:0] dt_rise;
    logic            valid;
    logic            stuck;
    logic            fault;

    typedef struct {
        int duty;
        int period;
        int dtf;
        int dtr;
        int stuck;
    } rec_t;

    rec_t cap_q[$];
    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pwm_capture #(.DIV(DIV), .W(W), .DT_W(DT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s),
        .nots      (nots),
        .fault_clr (fault_clr),
        .duty      (duty),
        .period    (period),
        .dt_fall   (dt_fall),
        .dt_rise   (dt_rise),
        .valid     (valid),
        .stuck     (stuck),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Record every published result set, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            rec_t r;
            r.duty   = int'(duty);
            r.period = int'(period);
            r.dtf    = int'(dt_fall);
            r.dtr    = int'(dt_rise);
            r.stuck  = int'(stuck);
            cap_q.push_back(r);
        end
    end

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected result for one period described by its segment lengths in clocks.
    function automatic rec_t model(input int h, input int g1, input int l,
                                   input int g2, input bit has_nots);
        rec_t r;
        r.duty   = h / DIV;
        r.period = (h + g1 + l + g2) / DIV;
        r.dtf    = has_nots ? min_int(g1, MAXD) : 0;
        r.dtr    = has_nots ? min_int(g2, MAXD) : 0;
        r.stuck  = 0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input integer obs,
                               input integer exp, input integer tol);
        checks++;
        assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic nv, input int cycles);
        s    = sv;
        nots = nv;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic compareQueues(input string phase);
        int n;
        checkOutput({phase, " count"}, cap_q.size(), exp_q.size(), 0);
        n = min_int(cap_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d] duty", phase, i), cap_q[i].duty, exp_q[i].duty, 1);
            checkOutput($sformatf("%s[%0d] period", phase, i), cap_q[i].period, exp_q[i].period, 1);
            checkOutput($sformatf("%s[%0d] dt_fall", phase, i), cap_q[i].dtf, exp_q[i].dtf, 1);
            checkOutput($sformatf("%s[%0d] dt_rise", phase, i), cap_q[i].dtr, exp_q[i].dtr, 1);
            checkOutput($sformatf("%s[%0d] stuck", phase, i), cap_q[i].stuck, exp_q[i].stuck, 0);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, " duty"}, duty, 0, 0);
        checkOutput({phase, " period"}, period, 0, 0);
        checkOutput({phase, " dt_fall"}, dt_fall, 0, 0);
        checkOutput({phase, " dt_rise"}, dt_rise, 0, 0);
        checkOutput({phase, " valid"}, valid, 0, 0);
        checkOutput({phase, " stuck"}, stuck, 0, 0);
        checkOutput({phase, " fault"}, fault, 0, 0);
    endtask

    initial begin
        int h, g1, l, g2;

        rst       = 1'b1;
        s         = 1'b0;
        nots      = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        applyStimulus(0, 0, 20);
        checkOutput("idle valid", valid, 0, 0);
        checkOutput("idle duty", duty, 0, 0);

        // Complementary pair with random segments; first period forces dead-time saturation.
        $display("[TB] normal periods");
        for (int k = 0; k < 5; k++) begin
            h  = $urandom_range(60, 20);
            l  = $urandom_range(60, 20);
            g1 = (k == 0) ? 80 : $urandom_range(90, 4);
            g2 = (k == 0) ? 70 : $urandom_range(90, 4);
            exp_q.push_back(model(h, g1, l, g2, 1'b1));
            applyStimulus(1, 0, h);
            applyStimulus(0, 0, g1);
            applyStimulus(0, 1, l);
            applyStimulus(0, 0, g2);
        end
        applyStimulus(1, 0, 10);
        compareQueues("normal");

        // s held high long enough for the period counter to saturate once.
        $display("[TB] stuck high");
        applyStimulus(1, 0, 700);
        checkOutput("stuck count", cap_q.size(), 1, 0);
        if (cap_q.size() > 0) begin
            checkOutput("stuck flag", cap_q[0].stuck, 1, 0);
            checkOutput("stuck duty", cap_q[0].duty, MAXP, 0);
            checkOutput("stuck period", cap_q[0].period, MAXP, 0);
            checkOutput("stuck dt_fall", cap_q[0].dtf, 0, 0);
            checkOutput("stuck dt_rise", cap_q[0].dtr, 0, 0);
        end
        cap_q.delete();

        // nots never toggles: square wave on s, first publish is a partial period.
        $display("[TB] missing nots");
        applyStimulus(0, 0, 40);
        for (int k = 0; k < 3; k++) begin
            h = $urandom_range(60, 20);
            l = $urandom_range(60, 20);
            exp_q.push_back(model(h, 0, l, 0, 1'b0));
            applyStimulus(1, 0, h);
            applyStimulus(0, 0, l);
        end
        applyStimulus(1, 0, 10);
        if (cap_q.size() > 0) begin
            void'(cap_q.pop_front());
        end
        compareQueues("no_nots");

        // Five-clock overlap while s is high.
        $display("[TB] shoot-through");
        checkOutput("fault idle", fault, 0, 0);
        applyStimulus(1, 1, 2);
        checkOutput("fault early", fault, 0, 0);
        applyStimulus(1, 1, 1);
        checkOutput("fault onset", fault, 1, 0);
        applyStimulus(1, 1, 2);
        applyStimulus(1, 0, 2);
        checkOutput("fault width", fault, 1, 0);
        applyStimulus(1, 0, 1);
        checkOutput("fault after overlap", fault, LATCH ? 1 : 0, 0);
        fault_clr = 1'b1;
        applyStimulus(1, 1, 6);
        checkOutput("fault clr vs overlap", fault, 1, 0);
        applyStimulus(1, 0, 6);
        checkOutput("fault cleared", fault, 0, 0);
        fault_clr = 1'b0;

        // Reset mid-HIGH with a live fault, then one full period is needed.
        $display("[TB] reset mid period");
        applyStimulus(1, 1, 4);
        rst  = 1'b1;
        nots = 1'b0;
        #1;
        checkAllZero("async reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
        applyStimulus(1, 0, 30);
        applyStimulus(0, 0, 40);
        h = $urandom_range(60, 20);
        l = $urandom_range(60, 20);
        applyStimulus(1, 0, h);
        applyStimulus(0, 0, l);
        checkOutput("no early valid", cap_q.size(), 0, 0);
        exp_q.push_back(model(h, 0, l, 0, 1'b0));
        applyStimulus(1, 0, 10);
        compareQueues("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
